// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master issues start_op/bin_in. The slave (converter) returns bcd_out/busy/done.
interface bin_to_bcd_seq_if #(
   parameter int MAX_WIDTH = 16,
   parameter int DIGITS    = 5
);
   logic                   start_op;
   logic [MAX_WIDTH-1:0]   bin_in;
   logic [4*DIGITS-1:0]    bcd_out;
   logic                   busy;
   logic                   done;

   modport master (output start_op, bin_in, input bcd_out, busy, done);
   modport slave  (input start_op, bin_in, output bcd_out, busy, done);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, start_op/done handshake
// compatible with the long divisor so results can be chained directly on done.
module bin_to_bcd_seq #(
   parameter int MAX_WIDTH = 16,
   parameter int DIGITS    = 5
) (
   input  logic              clk,
   input  logic              rst,
   bin_to_bcd_seq_if.slave   bus
);

   localparam int CNT_W = $clog2(MAX_WIDTH);
   localparam int BCD_W = 4 * DIGITS;
   localparam longint unsigned DEC_RANGE = longint'(10) ** DIGITS;
   localparam longint unsigned BIN_MAX   = (longint'(1) << MAX_WIDTH) - 1;

   if (DEC_RANGE <= BIN_MAX) begin : g_digits_too_few
      $error("bin_to_bcd_seq: DIGITS too small to hold 2**MAX_WIDTH-1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OP   = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [CNT_W-1:0]      cnt;
   logic [MAX_WIDTH-1:0]  bin_sr, bin_shift;
   logic [BCD_W-1:0]      bcd_sr, bcd_adj, bcd_shift;
   logic [BCD_W-1:0]      bcd_q;
   logic                  busy, done;

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      bcd_adj = bcd_sr;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
      bcd_shift = {bcd_adj[BCD_W-2:0], bin_sr[MAX_WIDTH-1]};
      bin_shift = {bin_sr[MAX_WIDTH-2:0], 1'b0};
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start_op) state_next = OP;
         OP:      if (cnt == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the shift registers are reset too. They are tiny, and a clean restart after an aborted conversion is worth it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         bin_sr <= '0;
         bcd_sr <= '0;
         bcd_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start_op) begin
                  bin_sr <= bus.bin_in;
                  bcd_sr <= '0;
                  cnt    <= CNT_W'(MAX_WIDTH - 1);
               end
            end
            OP: begin
               bin_sr <= bin_shift;
               bcd_sr <= bcd_shift;
               if (cnt != '0) cnt <= cnt - 1'b1;
               // Publish on the final shift so bcd_out is already valid while done is high.
               if (cnt == '0) bcd_q <= bcd_shift;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   assign bus.bcd_out = bcd_q;
   assign bus.busy    = busy;
   assign bus.done    = done;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. The stimulus pushes expected BCD words into a queue.
// A monitor pops and compares them on every done pulse.
module tb_bin_to_bcd_seq;

   localparam int MW = 16;
   localparam int DG = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bin_to_bcd_seq_if #(.MAX_WIDTH(MW), .DIGITS(DG)) bus ();

   bin_to_bcd_seq #(.MAX_WIDTH(MW), .DIGITS(DG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   logic [4*DG-1:0] exp_q[$];
   int total_cnt = 0;
   int pass_cnt  = 0;
   int done_cnt  = 0;
   int push_cnt  = 0;

   // Reference: peel decimal digits off with plain division.
   function automatic logic [4*DG-1:0] ref_bcd(input int unsigned v);
      logic [4*DG-1:0] r;
      int unsigned     rest;
      r    = '0;
      rest = v;
      for (int i = 0; i < DG; i++) begin
         r[4*i +: 4] = 4'(rest % 10);
         rest        = rest / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
   endtask

   always @(negedge clk) begin
      if (!rst && bus.done) begin
         done_cnt++;
         if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
         else check("bcd_out", 32'(bus.bcd_out), 32'(exp_q.pop_front()));
      end
   end

   // Called at a negedge while the DUT is idle. Returns at the negedge that shows done.
   task automatic convert(input logic [MW-1:0] value, input logic [4*DG-1:0] expect_bcd,
                          input int glitch_at, input logic [MW-1:0] glitch_val,
                          output int lat, output int busy_cycles);
      bus.start_op = 1'b1;
      bus.bin_in   = value;
      exp_q.push_back(expect_bcd);
      push_cnt++;
      @(posedge clk);
      #1;
      bus.start_op = 1'b0;
      bus.bin_in   = MW'($urandom);
      lat          = 0;
      busy_cycles  = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         bus.start_op = (n == glitch_at);
         if (n == glitch_at) bus.bin_in = glitch_val;
         if (bus.busy) busy_cycles++;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
      bus.start_op = 1'b0;
      if (lat == 0) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, bc, q, r, dones_before;
      logic [MW-1:0] v;

      bus.start_op = 1'b0;
      bus.bin_in   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_bcd_out", 32'(bus.bcd_out), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Zero input: latency and busy window.
      convert(16'd0, 20'h00000, 0, '0, lat, bc);
      check("latency_zero", 32'(lat), 32'd17);
      check("busy_cycles_zero", 32'(bc), 32'd17);
      @(negedge clk);
      check("idle_after_done", 32'(bus.busy), 32'd0);

      // All ones, started in the cycle right after the previous done.
      convert(16'hFFFF, 20'h65535, 0, '0, lat, bc);
      check("latency_ffff", 32'(lat), 32'd17);
      check("busy_cycles_ffff", 32'(bc), 32'd17);
      @(negedge clk);

      // A second start while busy must be ignored.
      convert(16'd1234, 20'h01234, 5, 16'd99, lat, bc);
      check("latency_ignored_start", 32'(lat), 32'd17);
      repeat (20) @(negedge clk);
      check("single_done", 32'(done_cnt), 32'(push_cnt));

      // Reset mid-conversion: no done pulse, outputs cleared.
      bus.start_op = 1'b1;
      bus.bin_in   = 16'd4321;
      @(posedge clk);
      #1;
      bus.start_op = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_bcd_out", 32'(bus.bcd_out), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      dones_before = done_cnt;
      repeat (25) @(negedge clk);
      check("abort_no_done", 32'(done_cnt), 32'(dones_before));
      convert(16'd7, 20'h00007, 0, '0, lat, bc);
      @(negedge clk);

      // Chain from a long-division result: quotient, then remainder.
      q = 50000 / 7;
      r = 50000 % 7;
      convert(MW'(q), 20'h07142, 0, '0, lat, bc);
      @(negedge clk);
      convert(MW'(r), 20'h00006, 0, '0, lat, bc);
      @(negedge clk);

      // Random back-to-back conversions against the arithmetic model.
      for (int i = 0; i < 1000; i++) begin
         v = MW'($urandom);
         convert(v, ref_bcd(v), 0, '0, lat, bc);
         @(negedge clk);
      end

      repeat (25) @(negedge clk);
      check("all_done_seen", 32'(done_cnt), 32'(push_cnt));
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
